alu_rr_sched: RTL and testbench

ALU_RR_SCHED -- requirements
Module: alu_rr_sched

---
 rtl/alu_sched_pkg.sv | 11 +
 rtl/alu_core.sv | 24 ++
 rtl/alu_rr_sched.sv | 111 +++++++++++
 tb/tb_alu_rr_sched.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared constants and opcode encoding for the round-robin ALU scheduler.
package alu_sched_pkg;
  localparam int W_DEF = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;
endpackage

// File: rtl/alu_core.sv
// Combinational ALU: {carry/borrow, result} for ADD/SUB, {0, bitwise} for AND/XOR.
module alu_core
  import alu_sched_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [1:0]   sel_i,
  output logic [W:0]   res_o
);

  // Zero-extended add/sub leaves carry (or borrow as the wrapped sign bit) in the MSB.
  always_comb begin
    res_o = '0;
    case (op_e'(sel_i))
      OP_ADD:  res_o = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  res_o = {1'b0, a_i} - {1'b0, b_i};
      OP_AND:  res_o = {1'b0, a_i & b_i};
      default: res_o = {1'b0, a_i ^ b_i};
    endcase
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Two requesters share one ALU; round-robin grant, one pipeline stage, one-deep result slot each.
module alu_rr_sched
  import alu_sched_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [1:0]   req0_sel,
  input  logic [1:0]   req1_sel,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  input  logic         rsp0_ready,
  input  logic         rsp1_ready,
  output logic [W:0]   rsp0_data,
  output logic [W:0]   rsp1_data,
  output logic         busy
);

  logic         s1_vld_q, s1_own_q, last_q;
  logic [W-1:0] s1_a_q, s1_b_q;
  logic [1:0]   s1_sel_q;
  logic         rsp0_vld_q, rsp1_vld_q, rsp0_vld_d, rsp1_vld_d;
  logic [W:0]   rsp0_data_q, rsp1_data_q, rsp0_data_d, rsp1_data_d;
  logic         elig0, elig1, gnt0, gnt1, hs;
  logic [W:0]   alu_res;

  // A requester may issue only if it has nothing in stage 1 and its slot will be free at c+1.
  assign elig0 = req0_valid & ~(s1_vld_q & ~s1_own_q) & (~rsp0_vld_q | rsp0_ready);
  assign elig1 = req1_valid & ~(s1_vld_q &  s1_own_q) & (~rsp1_vld_q | rsp1_ready);
  // last_q holds the last granted requester; on contention the other one wins.
  assign gnt0  = ~wb_rst_i & elig0 & (~elig1 | last_q);
  assign gnt1  = ~wb_rst_i & elig1 & (~elig0 | ~last_q);
  assign hs    = gnt0 | gnt1;

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp0_valid = rsp0_vld_q;
  assign rsp1_valid = rsp1_vld_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign busy       = s1_vld_q | rsp0_vld_q | rsp1_vld_q;

  alu_core #(.W(W)) u_alu (
    .a_i   (s1_a_q),
    .b_i   (s1_b_q),
    .sel_i (s1_sel_q),
    .res_o (alu_res)
  );

  // Stage 1 captures the winner's operands at the handshake; pointer moves only on a handshake.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1_vld_q <= 1'b0;
      s1_own_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_sel_q <= '0;
      last_q   <= 1'b1;
    end else begin
      s1_vld_q <= hs;
      if (hs) begin
        s1_own_q <= gnt1;
        s1_a_q   <= gnt1 ? req1_a   : req0_a;
        s1_b_q   <= gnt1 ? req1_b   : req0_b;
        s1_sel_q <= gnt1 ? req1_sel : req0_sel;
        last_q   <= gnt1;
      end
    end
  end

  // Result slots: a load from stage 1 takes priority over a consumer pop.
  always_comb begin
    rsp0_vld_d  = rsp0_vld_q & ~rsp0_ready;
    rsp1_vld_d  = rsp1_vld_q & ~rsp1_ready;
    rsp0_data_d = rsp0_data_q;
    rsp1_data_d = rsp1_data_q;
    if (s1_vld_q && !s1_own_q) begin
      rsp0_vld_d  = 1'b1;
      rsp0_data_d = alu_res;
    end
    if (s1_vld_q && s1_own_q) begin
      rsp1_vld_d  = 1'b1;
      rsp1_data_d = alu_res;
    end
  end

  // Slot registers; reset drops any held or in-flight result.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rsp0_vld_q  <= 1'b0;
      rsp1_vld_q  <= 1'b0;
      rsp0_data_q <= '0;
      rsp1_data_q <= '0;
    end else begin
      rsp0_vld_q  <= rsp0_vld_d;
      rsp1_vld_q  <= rsp1_vld_d;
      rsp0_data_q <= rsp0_data_d;
      rsp1_data_q <= rsp1_data_d;
    end
  end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Self-checking bench for alu_rr_sched: directed scenarios plus randomized run against a reference model.
module tb_alu_rr_sched;
  logic       wb_clk_i = 1'b0, wb_rst_i = 1'b1;
  logic       req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [3:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [1:0] req0_sel = 0, req1_sel = 0;
  logic [4:0] rsp0_data, rsp1_data;
  int nvec = 0, nerr = 0;

  alu_rr_sched #(.W(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_sel(req0_sel), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp0_data(rsp0_data), .rsp1_data(rsp1_data), .busy(busy)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Reference result from plain integer arithmetic.
  function automatic logic [4:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    int ia, ib;
    ia = int'(a); ib = int'(b);
    case (s)
      2'd0:    return 5'(ia + ib);
      2'd1:    return {(ia < ib) ? 1'b1 : 1'b0, 4'(ia - ib)};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  // Behavioural model: who owns the ALU this cycle, what each slot holds, who was granted last.
  bit         m_s1_v, m_s1_own, m_last = 1'b1;
  logic [4:0] m_s1_res;
  bit         m_slot_v [2];
  logic [4:0] m_slot_d [2];

  function automatic bit m_elig(input int n);
    bit v, rr;
    v  = (n == 0) ? req0_valid : req1_valid;
    rr = (n == 0) ? rsp0_ready : rsp1_ready;
    return v && !(m_s1_v && m_s1_own == n[0]) && (!m_slot_v[n] || rr);
  endfunction

  function automatic bit m_ready(input int n);
    if (wb_rst_i || !m_elig(n)) return 1'b0;
    return !m_elig(1 - n) || (m_last != n[0]);
  endfunction

  always @(posedge wb_clk_i) begin
    int w;
    if (wb_rst_i) begin
      m_s1_v = 0; m_last = 1; m_slot_v[0] = 0; m_slot_v[1] = 0;
    end else begin
      w = m_ready(0) ? 0 : (m_ready(1) ? 1 : -1);
      for (int n = 0; n < 2; n++) begin
        if (m_s1_v && m_s1_own == n[0]) begin
          m_slot_v[n] = 1; m_slot_d[n] = m_s1_res;
        end else if (m_slot_v[n] && ((n == 0) ? rsp0_ready : rsp1_ready)) begin
          m_slot_v[n] = 0;
        end
      end
      m_s1_v = (w >= 0);
      if (w == 0) begin m_s1_own = 0; m_s1_res = ref_alu(req0_a, req0_b, req0_sel); m_last = 0; end
      if (w == 1) begin m_s1_own = 1; m_s1_res = ref_alu(req1_a, req1_b, req1_sel); m_last = 1; end
    end
  end

  task automatic tick();
    @(posedge wb_clk_i); #1;
  endtask

  task automatic do_reset();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0; wb_rst_i = 1;
    tick(); tick();
    wb_rst_i = 0;
  endtask

  task automatic test_reset();
    wb_rst_i = 1; req0_valid = 1; req1_valid = 1;
    @(negedge wb_clk_i);
    nvec++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin nerr++; $display("FAIL rst_ready: got %b%b want 00", req0_ready, req1_ready); end
    tick();
    @(negedge wb_clk_i);
    nvec++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin nerr++; $display("FAIL rst_ready2: got %b%b want 00", req0_ready, req1_ready); end
    nvec++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL rst_state: rsp_valid=%b%b busy=%b want 0", rsp0_valid, rsp1_valid, busy); end
    nvec++; if (rsp0_data !== 5'd0 || rsp1_data !== 5'd0) begin nerr++; $display("FAIL rst_data: got %h %h want 0 0", rsp0_data, rsp1_data); end
    tick();
    wb_rst_i = 0; req0_valid = 0; req1_valid = 0;
    tick();
  endtask

  task automatic test_add();
    do_reset();
    req0_valid = 1; req0_a = 4'b1001; req0_b = 4'b1001; req0_sel = 2'b00; rsp0_ready = 1;
    @(negedge wb_clk_i);
    nvec++; if (req0_ready !== 1'b1) begin nerr++; $display("FAIL add_hs: req0_ready=%b want 1", req0_ready); end
    tick(); req0_valid = 0;
    @(negedge wb_clk_i);
    nvec++; if (rsp0_valid !== 1'b0 || busy !== 1'b1) begin nerr++; $display("FAIL add_c1: rsp0_valid=%b busy=%b want 0 1", rsp0_valid, busy); end
    tick();
    @(negedge wb_clk_i);
    nvec++; if (rsp0_valid !== 1'b1 || rsp0_data !== 5'b10010) begin nerr++; $display("FAIL add_rsp: valid=%b data=%b want 1 10010", rsp0_valid, rsp0_data); end
    tick();
    @(negedge wb_clk_i);
    nvec++; if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL add_pop: rsp0_valid=%b busy=%b want 0 0", rsp0_valid, busy); end
  endtask

  task automatic test_ops();
    logic [3:0] ta [3] = '{4'b0011, 4'b1100, 4'b1100};
    logic [3:0] tb [3] = '{4'b0101, 4'b1010, 4'b1010};
    logic [1:0] ts [3] = '{2'b01, 2'b10, 2'b11};
    logic [4:0] te [3] = '{5'b11110, 5'b01000, 5'b00110};
    do_reset();
    rsp1_ready = 1;
    for (int i = 0; i < 3; i++) begin
      req1_valid = 1; req1_a = ta[i]; req1_b = tb[i]; req1_sel = ts[i];
      @(negedge wb_clk_i);
      nvec++; if (req1_ready !== 1'b1) begin nerr++; $display("FAIL ops_hs%0d: req1_ready=%b want 1", i, req1_ready); end
      tick(); req1_valid = 0; tick();
      @(negedge wb_clk_i);
      nvec++; if (rsp1_valid !== 1'b1 || rsp1_data !== te[i]) begin nerr++; $display("FAIL ops_rsp%0d: valid=%b data=%b want 1 %b", i, rsp1_valid, rsp1_data, te[i]); end
      tick();
    end
  endtask

  task automatic test_alternate();
    do_reset();
    req0_valid = 1; req0_a = 4'd3; req0_b = 4'd4; req0_sel = 2'b00;
    req1_valid = 1; req1_a = 4'd5; req1_b = 4'd3; req1_sel = 2'b11;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge wb_clk_i);
      nvec++; if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin nerr++; $display("FAIL alt_grant%0d: ready=%b%b want %b%b", k, req0_ready, req1_ready, k % 2 == 0, k % 2 == 1); end
      nvec++; if (rsp0_valid !== (k >= 2 && k % 2 == 0) || rsp1_valid !== (k >= 2 && k % 2 == 1)) begin nerr++; $display("FAIL alt_rsp%0d: rsp_valid=%b%b", k, rsp0_valid, rsp1_valid); end
      if (k >= 2) begin
        nvec++; if ((k % 2 == 0) ? (rsp0_data !== 5'b00111) : (rsp1_data !== 5'b00110)) begin nerr++; $display("FAIL alt_data%0d: got %b %b want 00111/00110", k, rsp0_data, rsp1_data); end
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0; tick(); tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    req0_valid = 1; req0_a = 4'd1; req0_b = 4'd2; req0_sel = 2'b00; rsp0_ready = 0; rsp1_ready = 1;
    @(negedge wb_clk_i);
    nvec++; if (req0_ready !== 1'b1) begin nerr++; $display("FAIL bp_c0: req0_ready=%b want 1", req0_ready); end
    tick(); req0_a = 4'd2; req0_b = 4'd2;
    @(negedge wb_clk_i);
    nvec++; if (req0_ready !== 1'b0) begin nerr++; $display("FAIL bp_c1: req0_ready=%b want 0", req0_ready); end
    tick(); req1_valid = 1; req1_a = 4'd7; req1_b = 4'd2; req1_sel = 2'b01;
    @(negedge wb_clk_i);
    nvec++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin nerr++; $display("FAIL bp_c2: ready=%b%b want 01", req0_ready, req1_ready); end
    nvec++; if (rsp0_valid !== 1'b1 || rsp0_data !== 5'b00011) begin nerr++; $display("FAIL bp_hold: valid=%b data=%b want 1 00011", rsp0_valid, rsp0_data); end
    tick(); req1_valid = 0;
    @(negedge wb_clk_i);
    nvec++; if (req0_ready !== 1'b0 || rsp0_valid !== 1'b1 || rsp0_data !== 5'b00011) begin nerr++; $display("FAIL bp_c3: ready=%b valid=%b data=%b want 0 1 00011", req0_ready, rsp0_valid, rsp0_data); end
    tick(); rsp0_ready = 1;
    @(negedge wb_clk_i);
    nvec++; if (req0_ready !== 1'b1) begin nerr++; $display("FAIL bp_release: req0_ready=%b want 1", req0_ready); end
    nvec++; if (rsp1_valid !== 1'b1 || rsp1_data !== 5'b00101) begin nerr++; $display("FAIL bp_r1: valid=%b data=%b want 1 00101", rsp1_valid, rsp1_data); end
    tick(); req0_valid = 0;
    @(negedge wb_clk_i);
    nvec++; if (rsp0_valid !== 1'b0) begin nerr++; $display("FAIL bp_c5: rsp0_valid=%b want 0", rsp0_valid); end
    tick();
    @(negedge wb_clk_i);
    nvec++; if (rsp0_valid !== 1'b1 || rsp0_data !== 5'b00100) begin nerr++; $display("FAIL bp_c6: valid=%b data=%b want 1 00100", rsp0_valid, rsp0_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0_valid = 1; req0_a = 4'd5; req0_b = 4'd5; req0_sel = 2'b00; rsp0_ready = 1; rsp1_ready = 1;
    @(negedge wb_clk_i);
    nvec++; if (req0_ready !== 1'b1) begin nerr++; $display("FAIL rm_hs: req0_ready=%b want 1", req0_ready); end
    tick(); wb_rst_i = 1; req0_valid = 0; req1_valid = 1;
    @(negedge wb_clk_i);
    nvec++; if (req1_ready !== 1'b0) begin nerr++; $display("FAIL rm_rdy: req1_ready=%b want 0", req1_ready); end
    tick(); wb_rst_i = 0; req1_valid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge wb_clk_i);
      nvec++; if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL rm_drop%0d: rsp0_valid=%b busy=%b want 0 0", k, rsp0_valid, busy); end
      tick();
    end
    req0_valid = 1; req1_valid = 1;
    @(negedge wb_clk_i);
    nvec++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin nerr++; $display("FAIL rm_ptr: ready=%b%b want 10", req0_ready, req1_ready); end
    tick(); req0_valid = 0; req1_valid = 0; tick(); tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      req0_valid = ($urandom_range(0, 3) != 0); req1_valid = ($urandom_range(0, 3) != 0);
      req0_a = 4'($urandom); req0_b = 4'($urandom); req0_sel = 2'($urandom);
      req1_a = 4'($urandom); req1_b = 4'($urandom); req1_sel = 2'($urandom);
      rsp0_ready = ($urandom_range(0, 2) != 0); rsp1_ready = ($urandom_range(0, 2) != 0);
      wb_rst_i = ($urandom_range(0, 59) == 0);
      @(negedge wb_clk_i);
      nvec++; if (req0_ready !== m_ready(0) || req1_ready !== m_ready(1)) begin nerr++; $display("FAIL rnd_ready@%0d: got %b%b want %b%b", k, req0_ready, req1_ready, m_ready(0), m_ready(1)); end
      nvec++; if (rsp0_valid !== m_slot_v[0] || rsp1_valid !== m_slot_v[1]) begin nerr++; $display("FAIL rnd_valid@%0d: got %b%b want %b%b", k, rsp0_valid, rsp1_valid, m_slot_v[0], m_slot_v[1]); end
      nvec++; if ((m_slot_v[0] && rsp0_data !== m_slot_d[0]) || (m_slot_v[1] && rsp1_data !== m_slot_d[1])) begin nerr++; $display("FAIL rnd_data@%0d: got %b %b want %b %b", k, rsp0_data, rsp1_data, m_slot_d[0], m_slot_d[1]); end
      nvec++; if (busy !== (m_s1_v | m_slot_v[0] | m_slot_v[1])) begin nerr++; $display("FAIL rnd_busy@%0d: got %b want %b", k, busy, m_s1_v | m_slot_v[0] | m_slot_v[1]); end
      tick();
    end
    wb_rst_i = 0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_ops();
    test_alternate();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
